// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
// Shared definitions for the bit-serial adder:
//   - state_t : controller state encoding (IDLE / SHIFT / DONE)
//   - SERIAL_ADDER_DEFAULT_WIDTH : default operand width
//   - cnt_width() : bit counter width for a given operand width
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;

  // Counter must hold 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/half_adder.sv
// -----------------------------------------------------------------------------
// half_adder
// Single-bit half adder cell.
// Ports:
//   a, b : input bits
//   s    : sum bit   (a ^ b)
//   c    : carry bit (a & b)
// -----------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);

  assign s = a ^ b;
  assign c = a & b;

endmodule : half_adder

// File: rtl/serial_adder_full_adder_cell.sv
// -----------------------------------------------------------------------------
// full_adder_cell
// Single-bit full adder built from two half adders; the carry-out is the OR
// of the two half-adder carries (they can never both be 1).
// Ports:
//   x, y : operand bits
//   ci   : carry in
//   s    : sum bit       (x ^ y ^ ci)
//   co   : carry out     (majority of x, y, ci)
// -----------------------------------------------------------------------------
module full_adder_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  logic w_s0;
  logic w_c0;
  logic w_c1;

  half_adder u_ha0 (
    .a (x),
    .b (y),
    .s (w_s0),
    .c (w_c0)
  );

  half_adder u_ha1 (
    .a (w_s0),
    .b (ci),
    .s (s),
    .c (w_c1)
  );

  assign co = w_c0 | w_c1;

endmodule : full_adder_cell

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
// Bit-serial unsigned adder. Operands are captured on an accepted start,
// then shifted LSB-first through one full_adder_cell with a registered carry.
// After WIDTH shift cycles the assembled result is copied to sum/cout and
// done pulses for one cycle. Partial results never appear on sum.
//
// Optional build macro: SERIAL_ADDER_CIN_EN
//   defined     -> extra input cin, captured at start as the initial carry
//   not defined -> initial carry is constant 0
//
// Parameters:
//   WIDTH : operand / sum width, 2..32
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   start : request, sampled only in IDLE
//   a, b  : operands, captured on accepted start
//   cin   : carry in (only with SERIAL_ADDER_CIN_EN)
//   busy  : high while shifting
//   done  : one-cycle pulse, sum/cout valid
//   sum   : result, held until the next completion
//   cout  : carry out of the MSB, held with sum
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;

  logic             w_carry_init;
  logic             w_fa_s;
  logic             w_fa_co;
  logic [WIDTH-1:0] w_res_next;
  logic             w_last;

`ifdef SERIAL_ADDER_CIN_EN
  assign w_carry_init = cin;
`else
  assign w_carry_init = 1'b0;
`endif

  full_adder_cell u_fa (
    .x  (r_a_sr[0]),
    .y  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_fa_s),
    .co (w_fa_co)
  );

  // Result enters from the MSB side so that after WIDTH shifts bit 0 of the
  // operands has landed in bit 0 of the result.
  assign w_res_next = {w_fa_s, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == LAST_CNT);

  // ---------------------------------------------------------------------------
  // Controller: state register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Controller: next state and decoded outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_next = SHIFT;
      end
      SHIFT: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done         = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a_sr  <= a;
            r_b_sr  <= b;
            r_res   <= '0;
            r_carry <= w_carry_init;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_res   <= w_res_next;
          r_carry <= w_fa_co;
          r_cnt   <= r_cnt + CNT_W'(1);
          // The MSB edge publishes the completed word; sum is untouched
          // on every other edge.
          if (w_last) begin
            r_sum  <= w_res_next;
            r_cout <= w_fa_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8). A transaction-level model
// tracks the expected handshake phase and the arithmetic result (plain a+b),
// and every cycle the DUT outputs are compared against it. Directed vectors
// add hand-computed literal expectations on top.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  localparam int W = 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a     = '0;
  logic [W-1:0] b     = '0;
`ifdef SERIAL_ADDER_CIN_EN
  logic         cin   = 1'b0;
`endif

  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int n_done   = 0;
  int n_busy   = 0;
  bit cmp_en   = 1'b0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef SERIAL_ADDER_CIN_EN
    .cin   (cin),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model: m_phase counts cycles since acceptance
  // (0 = idle, 1..W = busy, W+1 = done cycle). The result is plain addition.
  // ---------------------------------------------------------------------------
  int           m_phase = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic [W:0]   m_op    = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_sum   <= '0;
      m_cout  <= 1'b0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
`ifdef SERIAL_ADDER_CIN_EN
        m_op <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
`else
        m_op <= {1'b0, a} + {1'b0, b};
`endif
      end
    end else if (m_phase == W + 1) begin
      m_phase <= 0;
    end else begin
      m_phase <= m_phase + 1;
      if (m_phase == W) begin
        m_sum  <= m_op[W-1:0];
        m_cout <= m_op[W];
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model, plus pulse tallies.
  task automatic compare_all();
    if (done) n_done++;
    if (busy) n_busy++;
    if (cmp_en) begin
      check("model_busy", 32'(busy), 32'((m_phase >= 1) && (m_phase <= W)));
      check("model_done", 32'(done), 32'(m_phase == W + 1));
      check("model_sum",  32'(sum),  32'(m_sum));
      check("model_cout", 32'(cout), 32'(m_cout));
    end
  endtask

  // Advance one cycle: compare at the falling edge, then step off it so
  // stimulus changes are well clear of both edges.
  task automatic tick();
    @(negedge clk);
    compare_all();
    #1;
  endtask

  int t_start;

  // Present a request for one cycle; operands are scrambled afterwards
  // since they must only matter on the accepting edge.
  task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    start   = 1'b1;
    a       = ta;
    b       = tb_v;
    t_start = cyc;
    tick();
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
  endtask

  task automatic wait_done(output int t_done);
    bit found;
    found  = 1'b0;
    t_done = -1;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (done) begin
        found  = 1'b1;
        t_done = cyc;
      end
    end
    if (!found) check("done_timeout", 32'd0, 32'd1);
  endtask

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] vsum;
    logic         vcout;
  } vec_t;

  vec_t vecs[3] = '{
    '{8'hAA, 8'h55, 8'hFF, 1'b0},
    '{8'h7F, 8'h01, 8'h80, 1'b0},
    '{8'hFF, 8'hFF, 8'hFE, 1'b1}
  };

  int t_d1, t_d2, snap_done, snap_busy;

  initial begin
    // Reset
    rst_n = 1'b0;
    tick();
    tick();
    cmp_en = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    // 0x3C + 0x25
    snap_busy = n_busy;
    start_op(8'h3C, 8'h25);
    wait_done(t_d1);
    check("lat_3c25",  32'(t_d1 - t_start), 32'd9);
    check("busy_len",  32'(n_busy - snap_busy), 32'd8);
    check("sum_3c25",  32'(sum),  32'h61);
    check("cout_3c25", 32'(cout), 32'd0);

    // Hold: result stays put with no request
    snap_done = n_done;
    repeat (20) tick();
    check("hold_sum",  32'(sum),  32'h61);
    check("hold_cout", 32'(cout), 32'd0);
    check("hold_done", 32'(n_done - snap_done), 32'd0);

    // 0xFF + 0x01, then 0x80 + 0x80 in the IDLE cycle right after done
    start_op(8'hFF, 8'h01);
    wait_done(t_d1);
    check("sum_ff01",  32'(sum),  32'h00);
    check("cout_ff01", 32'(cout), 32'd1);
    tick();
    start_op(8'h80, 8'h80);
    wait_done(t_d2);
    check("b2b_gap",   32'(t_d2 - t_d1), 32'd10);
    check("sum_8080",  32'(sum),  32'h00);
    check("cout_8080", 32'(cout), 32'd1);
    tick();

    // Start re-pulsed during busy cycle 3 must be ignored
    snap_done = n_done;
    start_op(8'h12, 8'h34);
    tick();
    tick();
    check("busy_c3", 32'(busy), 32'd1);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    tick();
    start = 1'b0;
    wait_done(t_d1);
    check("sum_1234",  32'(sum),  32'h46);
    check("cout_1234", 32'(cout), 32'd0);
    repeat (12) tick();
    check("one_done", 32'(n_done - snap_done), 32'd1);

    // Reset during busy cycle 4 aborts the operation
    start_op(8'h55, 8'h66);
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_sum",  32'(sum),  32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    snap_done = n_done;
    repeat (15) tick();
    check("abort_nodone", 32'(n_done - snap_done), 32'd0);
    start_op(8'h01, 8'h01);
    wait_done(t_d1);
    check("sum_0101", 32'(sum), 32'h02);
    tick();

    // Additional directed vectors
    foreach (vecs[i]) begin
      start_op(vecs[i].va, vecs[i].vb);
      wait_done(t_d1);
      check("vec_sum",  32'(sum),  32'(vecs[i].vsum));
      check("vec_cout", 32'(cout), 32'(vecs[i].vcout));
      tick();
    end

`ifdef SERIAL_ADDER_CIN_EN
    cin = 1'b1;
    start_op(8'hFF, 8'h00);
    cin = 1'b0;
    wait_done(t_d1);
    check("cin1_sum",  32'(sum),  32'h00);
    check("cin1_cout", 32'(cout), 32'd1);
    tick();
    cin = 1'b0;
    start_op(8'hFF, 8'h00);
    cin = 1'b1;
    wait_done(t_d1);
    check("cin0_sum",  32'(sum),  32'hFF);
    check("cin0_cout", 32'(cout), 32'd0);
    tick();
`endif

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_serial_adder
